// File: rtl/ddram_arb_pkg.sv
// Shared types and sizes for the two-client DDRAM burst arbiter.
package ddram_arb_pkg;
  localparam int NUM_CLIENTS = 2;
  localparam int BEAT_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/ddram_arb_pick.sv
// Two-way request picker: a lone requester wins; on contention either
// alternate against the last grant or let client 0 win outright.
module ddram_arb_pick
  import ddram_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic                   last_i,
  output logic                   pick_o
);
  always_comb begin
    pick_o = 1'b0;
    if (req_i == 2'b10)      pick_o = 1'b1;
    else if (req_i == 2'b11) pick_o = ROUND_ROBIN ? ~last_i : 1'b0;
  end
endmodule

// File: rtl/ddram_arbiter.sv
// Shares the DDRAM Avalon port between two burst masters, one whole burst
// per grant; command, write data and read returns follow the granted client.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ADDR_W      = 29
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              c0_rd,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [7:0]        c0_burstcnt,
  input  logic [63:0]       c0_din,
  input  logic [7:0]        c0_be,
  output logic              c0_busy,
  output logic              c0_dout_ready,
  output logic [63:0]       c0_dout,
  input  logic              c1_rd,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [7:0]        c1_burstcnt,
  input  logic [63:0]       c1_din,
  input  logic [7:0]        c1_be,
  output logic              c1_busy,
  output logic              c1_dout_ready,
  output logic [63:0]       c1_dout,
  input  logic              DDRAM_BUSY,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  output logic              DDRAM_RD,
  output logic              DDRAM_WE,
  output logic [ADDR_W-1:0] DDRAM_ADDR,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE
);
  logic [NUM_CLIENTS-1:0]             rd, we, busy, rdy;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_CLIENTS-1:0][7:0]        bcnt, be;
  logic [NUM_CLIENTS-1:0][63:0]       din;

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d, last_q, last_d, cmd_done_q, cmd_done_d;
  logic [BEAT_W-1:0] beats_q, beats_d, len_q, len_d;
  logic              pick, rd_cmd, last_beat;

  assign rd   = {c1_rd, c0_rd};
  assign we   = {c1_we, c0_we};
  assign addr = {c1_addr, c0_addr};
  assign bcnt = {c1_burstcnt, c0_burstcnt};
  assign be   = {c1_be, c0_be};
  assign din  = {c1_din, c0_din};

  assign c0_busy       = busy[0];
  assign c1_busy       = busy[1];
  assign c0_dout_ready = rdy[0];
  assign c1_dout_ready = rdy[1];
  assign c0_dout       = DDRAM_DOUT;
  assign c1_dout       = DDRAM_DOUT;
  assign last_beat     = (beats_q == len_q - BEAT_W'(1));

  ddram_arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .req_i  (rd | we),
    .last_i (last_q),
    .pick_o (pick)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      beats_q    <= '0;
      len_q      <= '0;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      beats_q    <= beats_d;
      len_q      <= len_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    beats_d        = beats_q;
    len_d          = len_q;
    cmd_done_d     = cmd_done_q;
    busy           = '1;
    rdy            = '0;
    rd_cmd         = 1'b0;
    DDRAM_RD       = 1'b0;
    DDRAM_WE       = 1'b0;
    DDRAM_ADDR     = '0;
    DDRAM_BURSTCNT = '0;
    DDRAM_DIN      = '0;
    DDRAM_BE       = '0;
    if (state_q != IDLE) begin
      DDRAM_ADDR     = addr[gnt_q];
      DDRAM_BURSTCNT = bcnt[gnt_q];
      DDRAM_DIN      = din[gnt_q];
      DDRAM_BE       = be[gnt_q];
    end
    case (state_q)
      IDLE: begin
        if (|(rd | we)) begin
          gnt_d      = pick;
          last_d     = pick;
          len_d      = (bcnt[pick] == 8'd0) ? BEAT_W'(1) : BEAT_W'(bcnt[pick]);
          beats_d    = '0;
          cmd_done_d = 1'b0;
          state_d    = we[pick] ? WRITE : READ;
        end
      end
      WRITE: begin
        DDRAM_WE    = we[gnt_q];
        busy[gnt_q] = DDRAM_BUSY;
        if (we[gnt_q] && !DDRAM_BUSY) begin
          beats_d = beats_q + BEAT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        // The command goes out once; the grant stays until every beat is back.
        rd_cmd      = rd[gnt_q] & ~cmd_done_q;
        DDRAM_RD    = rd_cmd;
        busy[gnt_q] = cmd_done_q | DDRAM_BUSY;
        rdy[gnt_q]  = DDRAM_DOUT_READY;
        if (rd_cmd && !DDRAM_BUSY) cmd_done_d = 1'b1;
        if (DDRAM_DOUT_READY) begin
          beats_d = beats_q + BEAT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
